// File: rtl/clock_reset_pkg.sv
// ============================================================================
// Module      : clock_reset_pkg
// Description : Shared state encoding and widths for the reset sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package clock_reset_pkg;

    localparam int SOFT_COUNT_WIDTH = 8;

    typedef enum logic [2:0] {
        ASSERTED = 3'd0,
        SYNC     = 3'd1,
        HOLD     = 3'd2,
        RELEASE  = 3'd3,
        RUN      = 3'd4
    } reset_state_t;

endpackage

`default_nettype wire

// File: rtl/reset_synchronizer.sv
// ============================================================================
// Module      : reset_synchronizer
// Description : Async-assert / sync-deassert chain fed with a constant 1.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module reset_synchronizer #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clock,
    input  logic reset,
    output logic o_sync_arm,
    output logic o_sync_rst_n
);

    logic [SYNC_STAGES-1:0] r_chain;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_chain <= '0;
        end else begin
            r_chain <= {r_chain[SYNC_STAGES-2:0], 1'b1};
        end
    end

    // o_sync_arm is the D input of the output flop: the sequencer leaves SYNC
    // on the very edge at which the chain output captures its 1.
    assign o_sync_arm   = r_chain[SYNC_STAGES-2];
    assign o_sync_rst_n = r_chain[SYNC_STAGES-1];

endmodule

`default_nettype wire

// File: rtl/reset_sequencer.sv
// ============================================================================
// Module      : reset_sequencer
// Description : Staggered per-domain reset release with soft-reset support.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module reset_sequencer
    import clock_reset_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int HOLD_CYCLES = 16,
    parameter int NUM_DOMAINS = 4,
    parameter int STAGE_GAP   = 4
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        soft_reset,
    output logic [NUM_DOMAINS-1:0]      domain_reset_n,
    output logic                        all_released,
    output logic [SOFT_COUNT_WIDTH-1:0] soft_reset_count
);

    localparam int c_MAX_CNT = (HOLD_CYCLES > STAGE_GAP) ? HOLD_CYCLES : STAGE_GAP;
    localparam int c_CNT_W   = $clog2(c_MAX_CNT + 1);

    localparam logic [c_CNT_W-1:0]          c_HOLD_LAST = c_CNT_W'(HOLD_CYCLES - 1);
    localparam logic [c_CNT_W-1:0]          c_GAP_LAST  = c_CNT_W'(STAGE_GAP - 1);
    localparam logic [NUM_DOMAINS-1:0]      c_ALL_ON    = '1;
    localparam logic [SOFT_COUNT_WIDTH-1:0] c_SOFT_MAX  = '1;

    reset_state_t                r_state;
    reset_state_t                w_state_next;
    logic [c_CNT_W-1:0]          r_cnt;
    logic [c_CNT_W-1:0]          w_cnt_next;
    logic [NUM_DOMAINS-1:0]      r_dom;
    logic [NUM_DOMAINS-1:0]      w_dom_next;
    logic [NUM_DOMAINS-1:0]      w_dom_step;
    logic                        r_all;
    logic                        w_all_next;
    logic [SOFT_COUNT_WIDTH-1:0] r_soft;
    logic [SOFT_COUNT_WIDTH-1:0] w_soft_next;
    logic                        w_sync_arm;
    logic                        w_sync_rst_n;

    reset_synchronizer #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clock        (clock),
        .reset        (reset),
        .o_sync_arm   (w_sync_arm),
        .o_sync_rst_n (w_sync_rst_n)
    );

    // Domains are released lowest-index first, so the released set is
    // always a contiguous run of ones from bit 0.
    assign w_dom_step = (r_dom << 1) | NUM_DOMAINS'(1);

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_dom_next   = r_dom;
        w_all_next   = r_all;
        w_soft_next  = r_soft;

        case (r_state)
            ASSERTED, SYNC: begin
                w_cnt_next   = '0;
                w_state_next = w_sync_arm ? HOLD : SYNC;
            end

            HOLD, RELEASE: begin
                if (r_cnt == ((r_state == HOLD) ? c_HOLD_LAST : c_GAP_LAST)) begin
                    if (w_sync_rst_n) begin
                        w_dom_next = w_dom_step;
                        w_cnt_next = '0;
                        if (w_dom_step == c_ALL_ON) begin
                            w_all_next   = 1'b1;
                            w_state_next = RUN;
                        end else begin
                            w_state_next = RELEASE;
                        end
                    end
                end else begin
                    w_cnt_next = r_cnt + c_CNT_W'(1);
                end
            end

            RUN: begin
                if (soft_reset) begin
                    w_dom_next   = '0;
                    w_all_next   = 1'b0;
                    w_cnt_next   = '0;
                    w_state_next = HOLD;
                    if (r_soft != c_SOFT_MAX) begin
                        w_soft_next = r_soft + SOFT_COUNT_WIDTH'(1);
                    end
                end
            end

            default: begin
                w_state_next = ASSERTED;
                w_cnt_next   = '0;
                w_dom_next   = '0;
                w_all_next   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= ASSERTED;
            r_cnt   <= '0;
            r_dom   <= '0;
            r_all   <= 1'b0;
            r_soft  <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_dom   <= w_dom_next;
            r_all   <= w_all_next;
            r_soft  <= w_soft_next;
        end
    end

    assign domain_reset_n   = r_dom;
    assign all_released     = r_all;
    assign soft_reset_count = r_soft;

endmodule

`default_nettype wire

// File: tb/tb_reset_sequencer.sv
// ============================================================================
// Module      : tb_reset_sequencer
// Description : Self-checking bench for reset_sequencer (default + corner DUT).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_reset_sequencer;

    localparam int c_S = 2;

    logic       clock      = 1'b0;
    logic       reset      = 1'b0;
    logic       soft_reset = 1'b0;
    logic [3:0] dom_a;
    logic       all_a;
    logic [7:0] cnt_a;
    logic [0:0] dom_b;
    logic       all_b;
    logic [7:0] cnt_b;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    reset_sequencer #(
        .SYNC_STAGES (2), .HOLD_CYCLES (16), .NUM_DOMAINS (4), .STAGE_GAP (4)
    ) u_dut_a (
        .clock (clock), .reset (reset), .soft_reset (soft_reset),
        .domain_reset_n (dom_a), .all_released (all_a), .soft_reset_count (cnt_a)
    );

    reset_sequencer #(
        .SYNC_STAGES (2), .HOLD_CYCLES (1), .NUM_DOMAINS (1), .STAGE_GAP (4)
    ) u_dut_b (
        .clock (clock), .reset (reset), .soft_reset (soft_reset),
        .domain_reset_n (dom_b), .all_released (all_b), .soft_reset_count (cnt_b)
    );

    // Model: domain i of DUT d is released once the edge number reaches
    // origin + offset + i*gap; a soft reset moves the origin to its edge.
    int p_n [2] = '{4, 1};
    int p_h [2] = '{16, 1};
    int p_g [2] = '{4, 4};
    int m_edge   [2] = '{0, 0};
    int m_origin [2] = '{0, 0};
    int m_off    [2] = '{c_S + 16, c_S + 1};
    int m_soft   [2] = '{0, 0};

    function automatic logic [3:0] exp_dom(input int d);
        logic [3:0] r;
        r = '0;
        for (int i = 0; i < p_n[d]; i++) begin
            if (m_edge[d] >= m_origin[d] + m_off[d] + i * p_g[d]) r[i] = 1'b1;
        end
        return r;
    endfunction

    function automatic logic exp_all(input int d);
        return m_edge[d] >= m_origin[d] + m_off[d] + (p_n[d] - 1) * p_g[d];
    endfunction

    always @(posedge clock) begin
        for (int d = 0; d < 2; d++) begin
            if (!reset) begin
                m_edge[d]   <= 0;
                m_origin[d] <= 0;
                m_off[d]    <= c_S + p_h[d];
                m_soft[d]   <= 0;
            end else begin
                m_edge[d] <= m_edge[d] + 1;
                if (soft_reset && exp_all(d)) begin
                    m_origin[d] <= m_edge[d] + 1;
                    m_off[d]    <= p_h[d];
                    if (m_soft[d] < 255) m_soft[d] <= m_soft[d] + 1;
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    always @(negedge clock) begin
        if (!reset) begin
            check("cmp_dom_a_rst", 32'(dom_a), 0);
            check("cmp_all_a_rst", 32'(all_a), 0);
            check("cmp_cnt_a_rst", 32'(cnt_a), 0);
            check("cmp_dom_b_rst", 32'(dom_b), 0);
            check("cmp_all_b_rst", 32'(all_b), 0);
        end else begin
            check("cmp_dom_a", 32'(dom_a), 32'(exp_dom(0)));
            check("cmp_all_a", 32'(all_a), 32'(exp_all(0)));
            check("cmp_cnt_a", 32'(cnt_a), 32'(m_soft[0]));
            check("cmp_dom_b", 32'(dom_b), 32'(exp_dom(1)));
            check("cmp_all_b", 32'(all_b), 32'(exp_all(1)));
            check("cmp_cnt_b", 32'(cnt_b), 32'(m_soft[1]));
        end
    end

    task automatic power_on(input int cycles);
        reset = 1'b0;
        repeat (cycles) @(posedge clock);
        #2 reset = 1'b1;
    endtask

    // Edges 1..30 after reset release, with hand-computed literal checks.
    task automatic run_schedule(input bit hold_soft);
        for (int e = 1; e <= 30; e++) begin
            @(posedge clock);
            #1;
            case (e)
                2:  begin check("b_dom_e2", 32'(dom_b), 0); check("b_all_e2", 32'(all_b), 0); end
                3:  begin check("b_dom_e3", 32'(dom_b), 1); check("b_all_e3", 32'(all_b), 1); end
                17: check("dom_e17", 32'(dom_a), 32'h0);
                18: check("dom_e18", 32'(dom_a), 32'h1);
                21: check("dom_e21", 32'(dom_a), 32'h1);
                22: check("dom_e22", 32'(dom_a), 32'h3);
                25: check("dom_e25", 32'(dom_a), 32'h3);
                26: check("dom_e26", 32'(dom_a), 32'h7);
                29: begin check("dom_e29", 32'(dom_a), 32'h7); check("all_e29", 32'(all_a), 0); end
                30: begin
                    check("dom_e30", 32'(dom_a), 32'hF);
                    check("all_e30", 32'(all_a), 1);
                    check("cnt_e30", 32'(cnt_a), 0);
                end
                default: ;
            endcase
            if (hold_soft && e == 4)  soft_reset = 1'b1;
            if (hold_soft && e == 20) soft_reset = 1'b0;
        end
    endtask

    task automatic wait_all(input int budget);
        int i;
        i = 0;
        while (!all_a && i < budget) begin
            @(posedge clock);
            #1;
            i++;
        end
        if (!all_a) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_all_released: got 0 after %0d cycles, expected 1", budget);
        end
    endtask

    initial begin
        // Power-on and reset values
        repeat (3) @(posedge clock);
        #1;
        check("rst_dom", 32'(dom_a), 0);
        check("rst_all", 32'(all_a), 0);
        check("rst_cnt", 32'(cnt_a), 0);
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;
        run_schedule(1'b0);

        // Soft reset sampled at edge 40
        for (int e = 31; e <= 39; e++) begin
            @(posedge clock);
            #1;
        end
        soft_reset = 1'b1;
        @(posedge clock);
        #1 soft_reset = 1'b0;
        check("soft_dom_e40", 32'(dom_a), 32'h0);
        check("soft_all_e40", 32'(all_a), 0);
        check("soft_cnt_e40", 32'(cnt_a), 1);
        for (int e = 41; e <= 68; e++) begin
            @(posedge clock);
            #1;
            case (e)
                55: check("soft_dom_e55", 32'(dom_a), 32'h0);
                56: check("soft_dom_e56", 32'(dom_a), 32'h1);
                67: begin check("soft_dom_e67", 32'(dom_a), 32'h7); check("soft_all_e67", 32'(all_a), 0); end
                68: begin check("soft_dom_e68", 32'(dom_a), 32'hF); check("soft_all_e68", 32'(all_a), 1); end
                default: ;
            endcase
        end

        // Asynchronous abort mid-release, between edges 23 and 24
        @(posedge clock);
        #1 power_on(3);
        for (int e = 1; e <= 23; e++) @(posedge clock);
        #3 reset = 1'b0;
        #1;
        check("abort_dom", 32'(dom_a), 0);
        check("abort_all", 32'(all_a), 0);
        check("abort_b_dom", 32'(dom_b), 0);
        repeat (3) @(posedge clock);
        #2 reset = 1'b1;
        run_schedule(1'b0);

        // Soft reset held outside RUN is ignored
        @(posedge clock);
        #1 power_on(3);
        run_schedule(1'b1);
        check("ignored_cnt", 32'(cnt_a), 0);

        // Saturation of the soft-reset counter
        for (int k = 0; k < 260; k++) begin
            @(posedge clock);
            #1 soft_reset = 1'b1;
            @(posedge clock);
            #1 soft_reset = 1'b0;
            wait_all(200);
        end
        check("sat_cnt_a", 32'(cnt_a), 255);
        check("sat_cnt_b", 32'(cnt_b), 255);
        check("sat_all_a", 32'(all_a), 1);

        repeat (2) @(posedge clock);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
